// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle datapath.
// Define MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN to halt on unlisted 11xxxx opcodes instead of treating them as NOPs.
module multicycle_control #(
  parameter logic [3:0] ADD_SEL = 4'b0000,
  parameter logic [3:0] SUB_SEL = 4'b0001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic       DMEMWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       RegReadSel,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUSel,
  output logic       halted,
  output logic       retire,
  output logic [3:0] state_dbg
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3, ALU_WB = 4'd4,
    MEM_RD = 4'd5, MEM_WB = 4'd6, MEM_WR = 4'd7, LIMM_WB = 4'd8, BRANCH = 4'd9,
    JUMP = 4'd10, HALT = 4'd15
  } state_t;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = HALT;
`else
  localparam state_t ILLEGAL_NEXT = FETCH;
`endif
  state_t state, next;
  logic pcw, pcwc, irw, dmw, rw, ret;
  logic [1:0] cls;
  logic is_ld, is_st, is_limm, is_beq, is_j, is_halt;
  assign cls     = opcode[5:4];
  assign is_ld   = opcode == 6'b110000;
  assign is_st   = opcode == 6'b110001;
  assign is_limm = opcode[5:1] == 5'b11001;
  assign is_beq  = opcode == 6'b110100;
  assign is_j    = opcode == 6'b110110;
  assign is_halt = opcode == 6'b111111;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= next;
  always_comb begin
    next = FETCH;
    pcw = 1'b0;
    pcwc = 1'b0;
    irw = 1'b0;
    dmw = 1'b0;
    rw = 1'b0;
    ret = 1'b0;
    ALUSrcA = 1'b0;
    RegReadSel = 1'b0;
    MemtoReg = 2'b00;
    ALUSrcB = 2'b00;
    PCSource = 2'b00;
    ALUSel = 4'b0000;
    halted = 1'b0;
    case (state)
      FETCH: begin
        irw = 1'b1;
        pcw = 1'b1;
        ALUSrcB = 2'b01;
        ALUSel = ADD_SEL;
        next = DECODE;
      end
      DECODE: begin
        // select R1 early so B is valid when the memory/branch state begins
        RegReadSel = is_ld | is_st | is_limm | is_beq;
        next = cls == 2'b00 ? (opcode[3:0] == 4'd0 ? FETCH : EXEC_R) :
               cls != 2'b11 ? EXEC_I :
               is_ld ? MEM_RD : is_st ? MEM_WR : is_limm ? LIMM_WB :
               is_beq ? BRANCH : is_j ? JUMP : is_halt ? HALT : ILLEGAL_NEXT;
        ret = next == FETCH;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSel = opcode[3:0];
        next = ALU_WB;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = cls == 2'b01 ? 2'b10 : 2'b11;
        ALUSel = opcode[3:0];
        next = ALU_WB;
      end
      ALU_WB: begin
        rw = 1'b1;
        ret = 1'b1;
      end
      MEM_RD: next = MEM_WB;
      MEM_WB: begin
        rw = 1'b1;
        MemtoReg = 2'b01;
        ret = 1'b1;
      end
      MEM_WR: begin
        dmw = 1'b1;
        RegReadSel = 1'b1;
        ret = 1'b1;
      end
      LIMM_WB: begin
        RegReadSel = 1'b1;
        rw = 1'b1;
        MemtoReg = {1'b1, opcode[0]};
        ret = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        RegReadSel = 1'b1;
        ALUSel = SUB_SEL;
        pcwc = 1'b1;
        PCSource = 2'b10;
        ret = 1'b1;
      end
      JUMP: begin
        pcw = 1'b1;
        PCSource = 2'b10;
        ret = 1'b1;
      end
      HALT: begin
        halted = 1'b1;
        next = HALT;
      end
      default: next = FETCH;
    endcase
  end
  // reset forces FETCH, whose enables must still be suppressed while reset is held
  assign PCWrite     = pcw & ~reset;
  assign PCWriteCond = pcwc & ~reset;
  assign IRWrite     = irw & ~reset;
  assign DMEMWrite   = dmw & ~reset;
  assign RegWrite    = rw & ~reset;
  assign retire      = ret & ~reset;
  assign state_dbg   = state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-scenario checks of the multicycle control FSM.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite, ALUSrcA, RegReadSel;
  logic [1:0] MemtoReg, ALUSrcB, PCSource;
  logic [3:0] ALUSel, state_dbg;
  logic halted, retire;
  logic [22:0] obs;
  int n_cmp = 0;
  int n_fail = 0;
  logic [22:0] fetch_v, rst_v, dec_v, decb_v, decn_v, exr_v, wb_v, exi_s_v, exi_z_v;
  logic [22:0] mrd_v, mwb_v, mwr_v, lli_v, lhi_v, br_v, jmp_v, hlt_v;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .DMEMWrite(DMEMWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .RegReadSel(RegReadSel), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUSel(ALUSel), .halted(halted), .retire(retire),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign obs = {state_dbg, PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite, ALUSrcA,
                RegReadSel, MemtoReg, ALUSrcB, PCSource, ALUSel, halted, retire};

  // en = {PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite, ALUSrcA, RegReadSel}
  function automatic logic [22:0] v(input logic [3:0] st, input logic [6:0] en,
                                    input logic [1:0] m2r, input logic [1:0] asb,
                                    input logic [1:0] pcs, input logic [3:0] alus,
                                    input logic hlt, input logic ret);
    return {st, en, m2r, asb, pcs, alus, hlt, ret};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs !== rst_v) begin n_fail++; $display("FAIL reset_hold got %h want %h", obs, rst_v); end
    opcode = 6'b110001;
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs !== rst_v) begin n_fail++; $display("FAIL reset_hold_op got %h want %h", obs, rst_v); end
  endtask

  task automatic test_rtype();
    logic [22:0] e [4];
    e = '{fetch_v, dec_v, exr_v, wb_v};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin reset = 1'b0; opcode = 6'b000001; end
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL rtype cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
  endtask

  task automatic test_itype();
    logic [22:0] e [4];
    e = '{fetch_v, dec_v, exi_s_v, wb_v};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) opcode = 6'b010011;
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL itype_sext cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
    e = '{fetch_v, dec_v, exi_z_v, wb_v};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) opcode = 6'b100011;
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL itype_zext cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
  endtask

  task automatic test_load();
    logic [22:0] e [4];
    e = '{fetch_v, decb_v, mrd_v, mwb_v};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) opcode = 6'b110000;
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL load cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
  endtask

  task automatic test_store();
    logic [22:0] e [3];
    e = '{fetch_v, decb_v, mwr_v};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) opcode = 6'b110001;
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL store cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
  endtask

  task automatic test_limm();
    logic [22:0] e [3];
    e = '{fetch_v, decb_v, lli_v};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) opcode = 6'b110010;
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL lli cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
    e = '{fetch_v, decb_v, lhi_v};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) opcode = 6'b110011;
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL lhi cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
  endtask

  task automatic test_branch();
    logic [22:0] e [3];
    e = '{fetch_v, decb_v, br_v};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) opcode = 6'b110100;
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL beq cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
  endtask

  task automatic test_jump();
    logic [22:0] e [3];
    e = '{fetch_v, dec_v, jmp_v};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) opcode = 6'b110110;
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL jump cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
  endtask

  task automatic test_nop();
    logic [22:0] e [2];
    e = '{fetch_v, decn_v};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) opcode = 6'b000000;
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL nop cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] e [3];
    e = '{fetch_v, dec_v, exr_v};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) opcode = 6'b000001;
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL rmid cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== rst_v) begin n_fail++; $display("FAIL rmid_async got %h want %h", obs, rst_v); end
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs !== rst_v) begin n_fail++; $display("FAIL rmid_no_wb got %h want %h", obs, rst_v); end
  endtask

  task automatic test_illegal();
    logic [22:0] e [3];
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    e = '{fetch_v, dec_v, hlt_v};
`else
    e = '{fetch_v, decn_v, fetch_v};
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin reset = 1'b0; opcode = 6'b111000; end
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL illegal cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== rst_v) begin n_fail++; $display("FAIL illegal_reset got %h want %h", obs, rst_v); end
  endtask

  task automatic test_halt();
    logic [22:0] e [2];
    e = '{fetch_v, dec_v};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) begin reset = 1'b0; opcode = 6'b111111; end
      #1;
      n_cmp++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL halt cyc%0d got %h want %h", i + 1, obs, e[i]); end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) opcode = 6'b000001;
      #1;
      n_cmp++;
      if (obs !== hlt_v) begin n_fail++; $display("FAIL halt_hold cyc%0d got %h want %h", i, obs, hlt_v); end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (state_dbg !== 4'd0) begin n_fail++; $display("FAIL halt_async_state got %0d want 0", state_dbg); end
    n_cmp++;
    if (obs !== rst_v) begin n_fail++; $display("FAIL halt_async got %h want %h", obs, rst_v); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== fetch_v) begin n_fail++; $display("FAIL halt_release got %h want %h", obs, fetch_v); end
  endtask

  initial begin
    fetch_v = v(4'd0,  7'b1010000, 2'b00, 2'b01, 2'b00, 4'h0, 1'b0, 1'b0);
    rst_v   = v(4'd0,  7'b0000000, 2'b00, 2'b01, 2'b00, 4'h0, 1'b0, 1'b0);
    dec_v   = v(4'd1,  7'b0000000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0);
    decb_v  = v(4'd1,  7'b0000001, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0);
    decn_v  = v(4'd1,  7'b0000000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b1);
    exr_v   = v(4'd2,  7'b0000010, 2'b00, 2'b00, 2'b00, 4'h1, 1'b0, 1'b0);
    wb_v    = v(4'd4,  7'b0000100, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b1);
    exi_s_v = v(4'd3,  7'b0000010, 2'b00, 2'b10, 2'b00, 4'h3, 1'b0, 1'b0);
    exi_z_v = v(4'd3,  7'b0000010, 2'b00, 2'b11, 2'b00, 4'h3, 1'b0, 1'b0);
    mrd_v   = v(4'd5,  7'b0000000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0);
    mwb_v   = v(4'd6,  7'b0000100, 2'b01, 2'b00, 2'b00, 4'h0, 1'b0, 1'b1);
    mwr_v   = v(4'd7,  7'b0001001, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b1);
    lli_v   = v(4'd8,  7'b0000101, 2'b10, 2'b00, 2'b00, 4'h0, 1'b0, 1'b1);
    lhi_v   = v(4'd8,  7'b0000101, 2'b11, 2'b00, 2'b00, 4'h0, 1'b0, 1'b1);
    br_v    = v(4'd9,  7'b0100011, 2'b00, 2'b00, 2'b10, 4'h1, 1'b0, 1'b1);
    jmp_v   = v(4'd10, 7'b1000000, 2'b00, 2'b00, 2'b10, 4'h0, 1'b0, 1'b1);
    hlt_v   = v(4'd15, 7'b0000000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b1, 1'b0);
    test_reset();
    test_rtype();
    test_itype();
    test_load();
    test_store();
    test_limm();
    test_branch();
    test_jump();
    test_nop();
    test_reset_mid();
    test_illegal();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ADD_SEL, default 4'b0000, is the ALU select code for add.
REQ-002 Parameter SUB_SEL, default 4'b0001, is the ALU select code for subtract.
REQ-003 clk  input  1  is the single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  is the reset; it is asynchronous and active-high.
REQ-005 opcode  input  6  is the IR[31:26] field, sampled in DECODE and later states.
REQ-006 PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite  output  1 each  are the datapath write enables.
REQ-007 ALUSrcA, RegReadSel  output  1 each  are mux selects; RegReadSel=0 selects R3 and RegReadSel=1 selects R1.
REQ-008 MemtoReg, ALUSrcB, PCSource  output  2 each  are mux selects.
REQ-009 ALUSel  output  4  is the main ALU operation select.
REQ-010 halted  output  1  is high while the block is in HALT.
REQ-011 retire  output  1  is a one-cycle pulse in the final state of every completed instruction.
REQ-012 state_dbg  output  4  is the current state encoding.

Function
REQ-013 The block SHALL be a Moore FSM, with all outputs decoded from the registered state and the opcode; outputs not listed for a state are 0.
REQ-014 State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, LIMM_WB=8, BRANCH=9, JUMP=10, HALT=15.
REQ-015 FETCH SHALL drive IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUSel=ADD_SEL, PCSource=00, and then go to DECODE.
REQ-016 DECODE SHALL assert no enables and SHALL dispatch on opcode[5:4]:
  - 00 (nonzero) to EXEC_R
  - 01 or 10 to EXEC_I
  - 000000 (NOP) to FETCH with retire=1
REQ-017 DECODE SHALL dispatch opcodes in the 11xxxx class as follows:
  - 110000 LD to MEM_RD
  - 110001 ST to MEM_WR
  - 110010 LLI and 110011 LHI to LIMM_WB
  - 110100 BEQ to BRANCH
  - 110110 J to JUMP
  - 111111 HALT to HALT
REQ-018 EXEC_R SHALL drive ALUSrcA=1, ALUSrcB=00, RegReadSel=0, ALUSel=opcode[3:0], and then go to ALU_WB.
REQ-019 EXEC_I SHALL drive ALUSrcA=1, ALUSel=opcode[3:0], and ALUSrcB=10 (sign-extended) for class 01 or 11 (zero-extended) for class 10; it then goes to ALU_WB.
REQ-020 ALU_WB SHALL drive RegWrite=1, MemtoReg=00, and retire=1, and then go to FETCH.
REQ-021 MEM_RD goes to MEM_WB with no enables; MEM_WB SHALL drive RegWrite=1, MemtoReg=01, and retire=1, and then go to FETCH.
REQ-022 MEM_WR SHALL drive DMEMWrite=1, RegReadSel=1, and retire=1, and then go to FETCH.
REQ-023 LIMM_WB SHALL drive RegReadSel=1, RegWrite=1, MemtoReg=10 for LLI or 11 for LHI, and retire=1, and then go to FETCH.
REQ-024 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, RegReadSel=1, ALUSel=SUB_SEL, PCWriteCond=1, PCSource=10, and retire=1, and then go to FETCH.
REQ-025 JUMP SHALL drive PCWrite=1, PCSource=10, and retire=1, and then go to FETCH.
REQ-026 RegReadSel SHALL be 1 in DECODE for the LD, ST, LLI, LHI, and BEQ opcodes, so that B is valid one cycle early.
REQ-027 Latency in cycles: R/I=4, LD=4, ST=3, LLI/LHI=3, BEQ=3, J=3, NOP=2.
REQ-028 HALT SHALL hold all enables at 0 and halted=1 until reset.

Reset
REQ-029 Asserting reset SHALL force state to FETCH asynchronously.
REQ-030 While reset is high, every write enable and retire SHALL be 0, irrespective of state.
REQ-031 Reset asserted mid-instruction SHALL abandon the instruction with no retire pulse; the first FETCH follows the first rising edge after deassertion.

Configuration
REQ-032 The macro MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN SHALL control the handling of unlisted 11xxxx opcodes.
REQ-033 With the macro defined, DECODE SHALL go to HALT on an unlisted opcode.
REQ-034 Without the macro, DECODE SHALL treat an unlisted opcode as a NOP: it goes to FETCH with retire=1.

Verification
REQ-035 Release reset, then apply opcode 000001 → states 0,1,2,4,0; RegWrite=1 only in cycle 4; retire pulses once; ALUSel=0001 in EXEC_R.
REQ-036 Apply opcode 010011 → ALUSrcB=10 in EXEC_I; apply opcode 100011 → ALUSrcB=11; both take 4 cycles.
REQ-037 Apply LD 110000 → MemtoReg=01 with RegWrite in cycle 4; apply ST 110001 → DMEMWrite=1 in cycle 3 only, with RegReadSel=1.
REQ-038 Apply BEQ 110100 → PCWriteCond=1, ALUSel=SUB_SEL, PCSource=10 in cycle 3; PCWrite=0.
REQ-039 Apply 111111 → halted=1 and all enables 0 for 20 cycles; then pulse reset → state_dbg=0 asynchronously.
REQ-040 Apply 111000 → HALT with the macro defined, or FETCH after 2 cycles without it; also assert reset in EXEC_R → no RegWrite and no retire.
